// File: rtl/echo_path_emulator.sv
// rtl/echo_path_emulator.sv - far-end echo source with lagged 4-tap echo and shared sample timebase
//
// Purpose:
//    Runs the sample-phase counter shared with the echo canceller. Once per
//    sample period it captures x[n] and the near-end sample. It then returns
//    sat(local + sum coef_k * x[n-LAG-k]), computed with one MAC per clock.
//
// Ports:
//    clk_operation           operation clock
//    rst                     asynchronous active-high reset
//    enable                  gates sampling ticks (counter always runs)
//    sampling_cycle[12:0]    sample period in clocks (clamped up to MIN_PERIOD)
//    sig16b[15:0]            transmitted sample x[n], signed
//    sig16b_local[15:0]      near-end sample, signed
//    coef_0..coef_3[15:0]    echo tap gains, signed Q1.15
//    sampling_cycle_counter  sample-phase counter
//    sig16b_lag[15:0]        echoed sample, signed, held between updates
//    ready                   one-cycle pulse when sig16b_lag updates
//    sat                     result clipped; held until the next ready

module echo_path_emulator #(
   parameter int LAG        = 4,
   parameter int MIN_PERIOD = 8
) (
   input  logic               clk_operation,
   input  logic               rst,
   input  logic               enable,
   input  logic [12:0]        sampling_cycle,
   input  logic signed [15:0] sig16b,
   input  logic signed [15:0] sig16b_local,
   input  logic signed [15:0] coef_0,
   input  logic signed [15:0] coef_1,
   input  logic signed [15:0] coef_2,
   input  logic signed [15:0] coef_3,
   output logic [12:0]        sampling_cycle_counter,
   output logic signed [15:0] sig16b_lag,
   output logic               ready,
   output logic               sat
);

   localparam int DEPTH = LAG + 4;

   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

   state_t             state;
   state_t             state_next;
   logic [12:0]        period;
   logic [12:0]        period_last;
   logic               tick;
   logic signed [15:0] hist [0:DEPTH-1];
   logic signed [15:0] coef_l [0:3];
   logic signed [35:0] acc;
   logic signed [35:0] acc_sum;
   logic [1:0]         k;
   logic signed [15:0] tap;
   logic signed [15:0] coef_sel;
   logic signed [31:0] product;
   logic signed [20:0] r;

   // Effective period, clamped so the 5-clock MAC always fits in one period.
   always_comb begin
      period      = (sampling_cycle < 13'(MIN_PERIOD)) ? 13'(MIN_PERIOD) : sampling_cycle;
      period_last = period - 13'd1;
   end

   // ">=" rather than "==" so a period shortened mid-flight wraps on the next clock.
   always_ff @(posedge clk_operation or posedge rst) begin
      if (rst) begin
         sampling_cycle_counter <= 13'd0;
      end else if (sampling_cycle_counter >= period_last) begin
         sampling_cycle_counter <= 13'd0;
      end else begin
         sampling_cycle_counter <= sampling_cycle_counter + 13'd1;
      end
   end

   assign tick = (sampling_cycle_counter == 13'd0) && enable && (state == IDLE);

   always_ff @(posedge clk_operation or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (tick) state_next = MAC;
         MAC:     if (k == 2'd3) state_next = OUT;
         OUT:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Tap k reads h[LAG+k], which after the tick holds x[n-LAG-k].
   always_comb begin
      tap      = hist[LAG];
      coef_sel = coef_l[0];
      unique case (k)
         2'd1: begin tap = hist[LAG+1]; coef_sel = coef_l[1]; end
         2'd2: begin tap = hist[LAG+2]; coef_sel = coef_l[2]; end
         2'd3: begin tap = hist[LAG+3]; coef_sel = coef_l[3]; end
         default: ;
      endcase
   end

   always_comb begin
      product = 32'(coef_sel) * 32'(tap);
      acc_sum = acc + 36'(product);
      // Floor of acc_sum / 2^15; the 21-bit range covers the worst-case sum of five Q30 terms.
      r       = acc_sum[35:15];
   end

   // The result is registered on the last MAC edge so that ready is high during
   // the OUT cycle, i.e. at counter 5 when the tick was taken at counter 0.
   always_ff @(posedge clk_operation or posedge rst) begin
      if (rst) begin
         for (int d = 0; d < DEPTH; d++) hist[d] <= 16'sd0;
         for (int c = 0; c < 4; c++) coef_l[c] <= 16'sd0;
         acc        <= 36'sd0;
         k          <= 2'd0;
         sig16b_lag <= 16'sd0;
         ready      <= 1'b0;
         sat        <= 1'b0;
      end else begin
         ready <= 1'b0;
         if (tick) begin
            hist[0] <= sig16b;
            for (int d = 1; d < DEPTH; d++) hist[d] <= hist[d-1];
            coef_l[0] <= coef_0;
            coef_l[1] <= coef_1;
            coef_l[2] <= coef_2;
            coef_l[3] <= coef_3;
            acc       <= {{5{sig16b_local[15]}}, sig16b_local, 15'd0};
            k         <= 2'd0;
         end else if (state == MAC) begin
            acc <= acc_sum;
            k   <= k + 2'd1;
            if (k == 2'd3) begin
               ready <= 1'b1;
               if (r > 21'sd32767) begin
                  sig16b_lag <= 16'sh7FFF;
                  sat        <= 1'b1;
               end else if (r < -21'sd32768) begin
                  sig16b_lag <= 16'sh8000;
                  sat        <= 1'b1;
               end else begin
                  sig16b_lag <= r[15:0];
                  sat        <= 1'b0;
               end
            end
         end
      end
   end

endmodule
